// File: rtl/gyro_spi_reader.sv
// Periodic SPI mode-3 burst reader for the IMU temperature, gyro and magnetometer registers.
// The seven output words hold the last complete frame and change only in the LATCH cycle.
module gyro_spi_reader #(
    parameter int         CLK_DIV     = 4,
    parameter int         POLL_CYCLES = 100000,
    parameter logic [7:0] START_REG   = 8'h41
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic        spi_cs_n,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic [15:0] Temp_Data,
    output logic [15:0] Gyro_Data_X,
    output logic [15:0] Gyro_Data_Y,
    output logic [15:0] Gyro_Data_Z,
    output logic [15:0] Mag_Data_X,
    output logic [15:0] Mag_Data_Y,
    output logic [15:0] Mag_Data_Z,
    output logic        data_valid,
    output logic        busy
);

    localparam int TIMER_W = (POLL_CYCLES > 2) ? $clog2(POLL_CYCLES) : 1;
    localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    localparam logic [TIMER_W-1:0] POLL_LAST = TIMER_W'(POLL_CYCLES - 1);
    localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [7:0]         CMD_BYTE  = {1'b1, START_REG[6:0]};
    localparam logic [3:0]         LAST_BYTE = 4'd14;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        XFER,
        CS_HOLD,
        LATCH
    } state_t;

    state_t               r_state;
    logic [TIMER_W-1:0]   r_pollTimer;
    logic [DIV_W-1:0]     r_divCnt;
    logic [2:0]           r_bitCnt;
    logic [3:0]           r_byteCnt;
    logic [7:0]           r_txShift;
    logic [111:0]         r_capture;

    logic w_divDone;
    logic w_lastBit;

    assign w_divDone = (r_divCnt == DIV_LAST);
    assign w_lastBit = (r_byteCnt == LAST_BYTE) && (r_bitCnt == 3'd7);

    // The capture register shifts all 120 received bits; the command byte's
    // echo falls off the top, leaving bytes 1..14 in big-endian order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_pollTimer <= '0;
            r_divCnt    <= '0;
            r_bitCnt    <= '0;
            r_byteCnt   <= '0;
            r_txShift   <= '0;
            r_capture   <= '0;
            spi_cs_n    <= 1'b1;
            spi_sclk    <= 1'b1;
            spi_mosi    <= 1'b0;
            Temp_Data   <= '0;
            Gyro_Data_X <= '0;
            Gyro_Data_Y <= '0;
            Gyro_Data_Z <= '0;
            Mag_Data_X  <= '0;
            Mag_Data_Y  <= '0;
            Mag_Data_Z  <= '0;
            data_valid  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (r_pollTimer == POLL_LAST) begin
                        if (enable) begin
                            r_pollTimer <= '0;
                            r_divCnt    <= '0;
                            r_bitCnt    <= '0;
                            r_byteCnt   <= '0;
                            r_txShift   <= CMD_BYTE;
                            spi_cs_n    <= 1'b0;
                            spi_sclk    <= 1'b1;
                            spi_mosi    <= CMD_BYTE[7];
                            busy        <= 1'b1;
                            r_state     <= CS_SETUP;
                        end
                    end else begin
                        r_pollTimer <= r_pollTimer + 1'b1;
                    end
                end

                CS_SETUP: begin
                    if (w_divDone) begin
                        r_divCnt <= '0;
                        spi_sclk <= 1'b0;
                        r_state  <= XFER;
                    end else begin
                        r_divCnt <= r_divCnt + 1'b1;
                    end
                end

                XFER: begin
                    if (!w_divDone) begin
                        r_divCnt <= r_divCnt + 1'b1;
                    end else begin
                        r_divCnt <= '0;
                        if (!spi_sclk) begin
                            spi_sclk  <= 1'b1;
                            r_capture <= {r_capture[110:0], spi_miso};
                        end else if (w_lastBit) begin
                            r_state <= CS_HOLD;
                        end else begin
                            // MOSI advances only on the falling edge that starts the next bit.
                            spi_sclk  <= 1'b0;
                            r_txShift <= {r_txShift[6:0], 1'b0};
                            spi_mosi  <= r_txShift[6];
                            r_bitCnt  <= r_bitCnt + 3'd1;
                            if (r_bitCnt == 3'd7) begin
                                r_byteCnt <= r_byteCnt + 4'd1;
                            end
                        end
                    end
                end

                CS_HOLD: begin
                    if (w_divDone) begin
                        r_divCnt    <= '0;
                        spi_cs_n    <= 1'b1;
                        data_valid  <= 1'b1;
                        Temp_Data   <= r_capture[111:96];
                        Gyro_Data_X <= r_capture[95:80];
                        Gyro_Data_Y <= r_capture[79:64];
                        Gyro_Data_Z <= r_capture[63:48];
                        Mag_Data_X  <= r_capture[47:32];
                        Mag_Data_Y  <= r_capture[31:16];
                        Mag_Data_Z  <= r_capture[15:0];
                        r_state     <= LATCH;
                    end else begin
                        r_divCnt <= r_divCnt + 1'b1;
                    end
                end

                LATCH: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gyro_spi_reader.sv
// Bench for gyro_spi_reader: an SPI slave model feeds byte patterns and queues the expected
// words; an independent monitor checks every data_valid against that queue.
module tb_gyro_spi_reader;

    localparam int CLK_DIV     = 4;
    localparam int POLL_CYCLES = 50;
    localparam int CS_LOW      = 242 * CLK_DIV;
    localparam int PERIOD      = POLL_CYCLES + CS_LOW + 1;

    typedef logic [7:0]       byteArr_t [14];
    typedef logic [6:0][15:0] frame_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        spi_cs_n;
    logic        spi_sclk;
    logic        spi_mosi;
    logic        spi_miso;
    logic [15:0] Temp_Data;
    logic [15:0] Gyro_Data_X;
    logic [15:0] Gyro_Data_Y;
    logic [15:0] Gyro_Data_Z;
    logic [15:0] Mag_Data_X;
    logic [15:0] Mag_Data_Y;
    logic [15:0] Mag_Data_Z;
    logic        data_valid;
    logic        busy;

    int       compared = 0;
    int       mismatched = 0;
    int       cycleNow = 0;
    int       holdViolations = 0;
    byteArr_t nextBytes;
    frame_t   expQ[$];
    frame_t   dutFrame;

    gyro_spi_reader #(
        .CLK_DIV    (CLK_DIV),
        .POLL_CYCLES(POLL_CYCLES),
        .START_REG  (8'h41)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .spi_cs_n   (spi_cs_n),
        .spi_sclk   (spi_sclk),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .Temp_Data  (Temp_Data),
        .Gyro_Data_X(Gyro_Data_X),
        .Gyro_Data_Y(Gyro_Data_Y),
        .Gyro_Data_Z(Gyro_Data_Z),
        .Mag_Data_X (Mag_Data_X),
        .Mag_Data_Y (Mag_Data_Y),
        .Mag_Data_Z (Mag_Data_Z),
        .data_valid (data_valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleNow <= cycleNow + 1;

    always_comb begin
        dutFrame    = '0;
        dutFrame[0] = Temp_Data;
        dutFrame[1] = Gyro_Data_X;
        dutFrame[2] = Gyro_Data_Y;
        dutFrame[3] = Gyro_Data_Z;
        dutFrame[4] = Mag_Data_X;
        dutFrame[5] = Mag_Data_Y;
        dutFrame[6] = Mag_Data_Z;
    end

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic reportTimeout(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: timed out waiting, got no event, expected one", name);
    endtask

    // Reference model: each word is two received bytes, high byte first.
    function automatic frame_t makeFrame(input byteArr_t b);
        frame_t f;
        for (int k = 0; k < 7; k++) f[k] = {b[2*k], b[2*k+1]};
        return f;
    endfunction

    function automatic byteArr_t randomBytes();
        byteArr_t b;
        for (int i = 0; i < 14; i++) b[i] = 8'($urandom);
        return b;
    endfunction

    function automatic byteArr_t rampBytes(input logic [7:0] first);
        byteArr_t b;
        for (int i = 0; i < 14; i++) b[i] = first + 8'(i);
        return b;
    endfunction

    task automatic applyStimulus(input byteArr_t b);
        nextBytes = b;
    endtask

    task automatic waitForCsFall(input int budget, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < budget) begin
            @(negedge clk);
            n++;
            if (spi_cs_n === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) reportTimeout("cs_n fall");
    endtask

    task automatic waitForValid(input int budget, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < budget) begin
            @(negedge clk);
            n++;
            if (data_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) reportTimeout("data_valid");
    endtask

    task automatic waitForRises(input int count, input int budget);
        int  rises = 0;
        int  n = 0;
        logic prev = spi_sclk;
        while (rises < count && n < budget) begin
            @(negedge clk);
            n++;
            if (prev === 1'b0 && spi_sclk === 1'b1) rises++;
            prev = spi_sclk;
        end
        if (rises < count) reportTimeout("sclk rising edges");
    endtask

    task automatic countCsActivity(input int cycles, output int lowCycles);
        lowCycles = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (spi_cs_n !== 1'b1) lowCycles++;
        end
    endtask

    // SPI slave: mode 3, shifts MISO on falling SCLK, observes MOSI on rising SCLK.
    initial begin : slaveModel
        logic [119:0] stream;
        logic [119:0] mosiBits;
        int fallCount, riseCount, startCycle, lastEdge, half, minHalf, maxHalf;
        spi_miso = 1'b1;
        forever begin
            @(negedge spi_cs_n);
            stream[119:112] = 8'($urandom);
            for (int i = 0; i < 14; i++) stream[111-8*i -: 8] = nextBytes[i];
            expQ.push_back(makeFrame(nextBytes));
            mosiBits   = '0;
            fallCount  = 0;
            riseCount  = 0;
            startCycle = cycleNow;
            lastEdge   = cycleNow;
            minHalf    = 1 << 30;
            maxHalf    = 0;
            while (spi_cs_n === 1'b0) begin
                @(negedge spi_sclk or posedge spi_sclk or posedge spi_cs_n);
                if (spi_cs_n !== 1'b0) break;
                half     = cycleNow - lastEdge;
                lastEdge = cycleNow;
                if (half < minHalf) minHalf = half;
                if (half > maxHalf) maxHalf = half;
                if (spi_sclk === 1'b0) begin
                    if (fallCount < 120) spi_miso = stream[119 - fallCount];
                    fallCount++;
                end else begin
                    riseCount++;
                    mosiBits = {mosiBits[118:0], spi_mosi};
                end
            end
            if (rst_n === 1'b0) begin
                if (expQ.size() > 0) void'(expQ.pop_back());
            end else begin
                checkOutput("cs_n low cycles", cycleNow - startCycle, CS_LOW);
                checkOutput("sclk rising edges", riseCount, 120);
                checkOutput("sclk min half period", minHalf, CLK_DIV);
                checkOutput("sclk max half period", maxHalf, CLK_DIV);
                checkOutput("mosi command byte", mosiBits[119:112], 8'hC1);
                checkOutput("mosi dummy bytes", mosiBits[111:0], 112'h0);
            end
            spi_miso = 1'b1;
        end
    end

    // Monitor: pops the expected frame on each data_valid and tracks output stability between latches.
    initial begin : monitor
        frame_t held = '0;
        frame_t exp;
        logic   prevValid = 1'b0;
        string  names[7] = '{"Temp", "GX", "GY", "GZ", "MX", "MY", "MZ"};
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                held      = '0;
                prevValid = 1'b0;
                continue;
            end
            if (prevValid) checkOutput("data_valid one cycle", data_valid, 1'b0);
            if (data_valid === 1'b1) begin
                checkOutput("outputs held between latches", holdViolations, 0);
                holdViolations = 0;
                if (expQ.size() == 0) begin
                    reportTimeout("expected frame for data_valid");
                end else begin
                    exp = expQ.pop_front();
                    for (int k = 0; k < 7; k++)
                        checkOutput($sformatf("%s word", names[k]), dutFrame[k], exp[k]);
                    held = exp;
                end
            end else if (dutFrame !== held) begin
                holdViolations++;
            end
            prevValid = data_valid;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : mainSeq
        int n;
        int lowCycles;
        bit ok;

        rst_n  = 1'b0;
        enable = 1'b1;
        applyStimulus(rampBytes(8'h01));
        repeat (5) @(negedge clk);
        checkOutput("reset cs_n", spi_cs_n, 1'b1);
        checkOutput("reset sclk", spi_sclk, 1'b1);
        checkOutput("reset mosi", spi_mosi, 1'b0);
        checkOutput("reset data_valid", data_valid, 1'b0);
        checkOutput("reset busy", busy, 1'b0);
        checkOutput("reset words", dutFrame, 112'h0);

        rst_n = 1'b1;
        waitForCsFall(200, n, ok);
        checkOutput("reset release to cs_n fall", n, POLL_CYCLES);
        checkOutput("busy during frame", busy, 1'b1);

        waitForValid(CS_LOW + 10, n, ok);
        applyStimulus(rampBytes(8'hF0));
        waitForValid(PERIOD + 10, n, ok);
        checkOutput("data_valid period", n, PERIOD);

        for (int f = 0; f < 3; f++) begin
            applyStimulus(randomBytes());
            waitForValid(PERIOD + 10, n, ok);
            checkOutput("data_valid period random", n, PERIOD);
        end

        $display("[TB] enable gating");
        enable = 1'b0;
        applyStimulus(randomBytes());
        countCsActivity(500, lowCycles);
        checkOutput("cs_n idle while disabled", lowCycles, 0);
        checkOutput("busy idle while disabled", busy, 1'b0);
        enable = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("cs_n falls after enable", spi_cs_n, 1'b0);

        $display("[TB] enable dropped mid-frame");
        waitForRises(40, 2000);
        enable = 1'b0;
        waitForValid(CS_LOW + 10, n, ok);
        checkOutput("data_valid after enable drop", ok, 1'b1);
        countCsActivity(1500, lowCycles);
        checkOutput("no frame after enable drop", lowCycles, 0);

        $display("[TB] reset mid-frame");
        applyStimulus(randomBytes());
        enable = 1'b1;
        waitForCsFall(200, n, ok);
        waitForRises(56, 2000);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid-reset cs_n", spi_cs_n, 1'b1);
        checkOutput("mid-reset sclk", spi_sclk, 1'b1);
        checkOutput("mid-reset words", dutFrame, 112'h0);
        checkOutput("mid-reset data_valid", data_valid, 1'b0);
        checkOutput("mid-reset busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(randomBytes());
        waitForCsFall(200, n, ok);
        checkOutput("restart to cs_n fall", n, POLL_CYCLES);
        waitForValid(CS_LOW + 10, n, ok);
        checkOutput("data_valid after reset", ok, 1'b1);

        repeat (5) @(negedge clk);
        checkOutput("scoreboard drained", expQ.size(), 0);
        checkOutput("trailing hold violations", holdViolations, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
